// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared state type, width helper and default 20 MHz WS2812B/SK6812 timing
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RES  = 2'd2
  } state_e;

  // 20 MHz clock: 0.4 us / 0.8 us high, 1.25 us bit, ~51 us latch
  localparam int WS_T0H  = 8;
  localparam int WS_T1H  = 16;
  localparam int WS_TBIT = 25;
  localparam int WS_TRES = 1024;

  function automatic int clog2(input int value);
    int width;
    int span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span * 2;
      width = width + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/ws2812_stream_driver_if.sv
// rtl/ws2812_stream_driver_if.sv - pixel slot stream between buffer/mapper and serialiser
interface ws2812_stream_driver_if #(
  parameter int NUM_CH       = 1,
  parameter int BITS_PER_LED = 24
);
  logic                             s_valid;
  logic                             s_ready;
  logic [NUM_CH*BITS_PER_LED-1:0]   s_data;
  logic                             s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/ws2812_bit_timer.sv
// rtl/ws2812_bit_timer.sv - shared bit/cycle counters and per-channel high/low compare
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int BITS_PER_LED = 24,
  parameter int T0H          = WS_T0H,
  parameter int T1H          = WS_T1H,
  parameter int TBIT         = WS_TBIT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run_i,
  input  logic [NUM_CH*BITS_PER_LED-1:0] pixel_i,
  output logic [NUM_CH-1:0]              hi_o,
  output logic                           bit_end_o,
  output logic                           pixel_end_o
);
  localparam int BW = clog2(TBIT);
  localparam int IW = clog2(BITS_PER_LED);
  localparam logic [BW-1:0] T0H_C    = BW'(T0H);
  localparam logic [BW-1:0] T1H_C    = BW'(T1H);
  localparam logic [BW-1:0] BIT_LAST = BW'(TBIT - 1);
  localparam logic [IW-1:0] MSB_IDX  = IW'(BITS_PER_LED - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] bidx_q, bidx_d;

  assign bit_end_o   = run_i && (bcnt_q == BIT_LAST);
  assign pixel_end_o = bit_end_o && (bidx_q == '0);

  // Counters sit cleared while not running, so entering SEND always starts at MSB, cycle 0
  always_comb begin
    bcnt_d = '0;
    bidx_d = MSB_IDX;
    if (run_i) begin
      if (bit_end_o) begin
        if (bidx_q != '0) bidx_d = bidx_q - 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
        bidx_d = bidx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
      bidx_q <= MSB_IDX;
    end else begin
      bcnt_q <= bcnt_d;
      bidx_q <= bidx_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [BITS_PER_LED-1:0] ch;
    assign ch      = pixel_i[c*BITS_PER_LED +: BITS_PER_LED];
    assign hi_o[c] = bcnt_q < (ch[bidx_q] ? T1H_C : T0H_C);
  end

endmodule

// File: rtl/ws2812_stream_driver.sv
// rtl/ws2812_stream_driver.sv - valid/ready pixel stream to NUM_CH lock-step LED strip serialiser
module ws2812_stream_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int BITS_PER_LED = 24,
  parameter int T0H          = WS_T0H,
  parameter int T1H          = WS_T1H,
  parameter int TBIT         = WS_TBIT,
  parameter int TRES         = WS_TRES
) (
  input  logic                  clk,
  input  logic                  reset,
  ws2812_stream_driver_if.slave s,
  output logic [NUM_CH-1:0]     led,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);
  localparam int DW = NUM_CH * BITS_PER_LED;
  localparam int RW = clog2(TRES + 1);
  localparam logic [RW-1:0] RES_END = RW'(TRES);

  state_e          state_q, state_d;
  logic [DW-1:0]   cur_q, cur_d, nxt_q, nxt_d;
  logic            cur_last_q, cur_last_d, nxt_last_q, nxt_last_d;
  logic            nxt_full_q, nxt_full_d, drop_q, drop_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic            fdone_q, fdone_d, urun_q, urun_d;
  logic [NUM_CH-1:0] hi;
  logic            run, bit_end, pixel_end, boundary, ready, accept, take_cur;

  assign ready     = !reset && ((state_q == RES) ? drop_q : !nxt_full_q);
  assign accept    = s.s_valid && ready;
  assign s.s_ready = ready;
  assign run       = (state_q == SEND);
  assign boundary  = bit_end && pixel_end;

  ws2812_bit_timer #(
    .NUM_CH(NUM_CH), .BITS_PER_LED(BITS_PER_LED),
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT)
  ) u_timer (
    .clk(clk), .reset(reset), .run_i(run), .pixel_i(cur_q),
    .hi_o(hi), .bit_end_o(bit_end), .pixel_end_o(pixel_end)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cur_last_d = cur_last_q;
    nxt_d      = nxt_q;
    nxt_last_d = nxt_last_q;
    nxt_full_d = nxt_full_q;
    drop_d     = drop_q;
    rcnt_d     = '0;
    led_d      = '0;
    fdone_d    = 1'b0;
    urun_d     = 1'b0;
    take_cur   = 1'b0;
    case (state_q)
      IDLE: begin
        // A slot parked in next during the previous frame's tail starts the new frame
        if (nxt_full_q) begin
          cur_d      = nxt_q;
          cur_last_d = nxt_last_q;
          nxt_full_d = 1'b0;
          state_d    = SEND;
        end else if (accept) begin
          cur_d      = s.s_data;
          cur_last_d = s.s_last;
          take_cur   = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        led_d = hi;
        if (boundary) begin
          if (cur_last_q) begin
            state_d = RES;
          end else if (nxt_full_q) begin
            cur_d      = nxt_q;
            cur_last_d = nxt_last_q;
            nxt_full_d = 1'b0;
          end else if (accept) begin
            cur_d      = s.s_data;
            cur_last_d = s.s_last;
            take_cur   = 1'b1;
          end else begin
            urun_d  = 1'b1;
            drop_d  = 1'b1;
            state_d = RES;
          end
        end
      end
      RES: begin
        rcnt_d = (rcnt_q == RES_END) ? rcnt_q : rcnt_q + 1'b1;
        if (accept && s.s_last) drop_d = 1'b0;
        if ((rcnt_q == RES_END) && !drop_q) begin
          state_d = IDLE;
          fdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Slots accepted in RES are discarded remains of an underrun frame
    if (accept && !take_cur && (state_q != RES)) begin
      nxt_d      = s.s_data;
      nxt_last_d = s.s_last;
      nxt_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      cur_last_q <= 1'b0;
      nxt_q      <= '0;
      nxt_last_q <= 1'b0;
      nxt_full_q <= 1'b0;
      drop_q     <= 1'b0;
      rcnt_q     <= '0;
      led_q      <= '0;
      fdone_q    <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cur_last_q <= cur_last_d;
      nxt_q      <= nxt_d;
      nxt_last_q <= nxt_last_d;
      nxt_full_q <= nxt_full_d;
      drop_q     <= drop_d;
      rcnt_q     <= rcnt_d;
      led_q      <= led_d;
      fdone_q    <= fdone_d;
      urun_q     <= urun_d;
    end
  end

  assign led        = led_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = fdone_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// tb/tb_ws2812_stream_driver.sv - directed self-checking bench for ws2812_stream_driver
module tb_ws2812_stream_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int ur_cnt_a = 0, ur_cyc_a = 0, fd_cnt_a = 0, fd_cyc_a = 0, fd_cnt_b = 0, ur_cnt_b = 0;

  logic       led_a, busy_a, fd_a, ur_a;
  logic [1:0] led_b;
  logic       busy_b, fd_b, ur_b;

  ws2812_stream_driver_if #(.NUM_CH(1), .BITS_PER_LED(24)) if_a ();
  ws2812_stream_driver_if #(.NUM_CH(2), .BITS_PER_LED(32)) if_b ();

  ws2812_stream_driver #(.NUM_CH(1), .BITS_PER_LED(24), .T0H(8), .T1H(16), .TBIT(25), .TRES(1024)) dut_a (
    .clk(clk), .reset(reset), .s(if_a), .led(led_a), .busy(busy_a), .frame_done(fd_a), .underrun(ur_a));

  ws2812_stream_driver #(.NUM_CH(2), .BITS_PER_LED(32), .T0H(8), .T1H(16), .TBIT(25), .TRES(1024)) dut_b (
    .clk(clk), .reset(reset), .s(if_b), .led(led_b), .busy(busy_b), .frame_done(fd_b), .underrun(ur_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ur_a) begin ur_cnt_a++; ur_cyc_a = cyc; end
    if (fd_a) begin fd_cnt_a++; fd_cyc_a = cyc; end
    if (fd_b) fd_cnt_b++;
    if (ur_b) ur_cnt_b++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slot(input bit sel_b, input logic [63:0] data, input logic last, output int stall);
    logic rdy;
    bit   done;
    stall = 0;
    done  = 0;
    if (sel_b) begin if_b.s_valid = 1'b1; if_b.s_data = data; if_b.s_last = last; end
    else begin if_a.s_valid = 1'b1; if_a.s_data = data[23:0]; if_a.s_last = last; end
    for (int k = 0; k < 4000 && !done; k++) begin
      rdy = sel_b ? if_b.s_ready : if_a.s_ready;
      tick();
      if (rdy) done = 1;
      else stall++;
    end
    if (!done) check("drive_timeout", 0, 1);
    if (sel_b) if_b.s_valid = 1'b0;
    else if_a.s_valid = 1'b0;
  endtask

  task automatic wait_rise(input bit sel_b, output int n);
    n = 0;
    while (!(sel_b ? |led_b : led_a) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check("rise_timeout", 0, 1);
  endtask

  // Decodes nbits bit periods from the current sample (bit MSB, cycle 0)
  task automatic rx_pixel(input bit sel_b, input int nbits, output logic [31:0] w0,
                          output logic [31:0] w1, output int bad);
    int h0, h1;
    bit low0, low1;
    logic l0, l1;
    w0 = '0; w1 = '0; bad = 0;
    for (int i = 0; i < nbits; i++) begin
      h0 = 0; h1 = 0; low0 = 0; low1 = 0;
      for (int j = 0; j < 25; j++) begin
        l0 = sel_b ? led_b[0] : led_a;
        l1 = sel_b ? led_b[1] : 1'b0;
        if (l0) begin if (low0) bad++; h0++; end else low0 = 1;
        if (l1) begin if (low1) bad++; h1++; end else low1 = 1;
        tick();
      end
      if (!(h0 == 8 || h0 == 16)) bad++;
      if (sel_b && !(h1 == 8 || h1 == 16)) bad++;
      w0 = {w0[30:0], h0 == 16};
      w1 = {w1[30:0], h1 == 16};
    end
  endtask

  task automatic wait_done(input bit sel_b, output int n, output int highs);
    n = 0; highs = 0;
    while (!(sel_b ? fd_b : fd_a) && n < 3000) begin
      if (sel_b ? |led_b : led_a) highs++;
      tick();
      n++;
    end
  endtask

  initial begin
    logic [31:0] w0, w1;
    int bad, n, h, st, t0, n0, fd0, ur0;
    if_a.s_valid = 1'b0; if_a.s_data = '0; if_a.s_last = 1'b0;
    if_b.s_valid = 1'b0; if_b.s_data = '0; if_b.s_last = 1'b0;
    repeat (3) tick();
    check("rst_led", led_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_underrun", ur_a, 0);
    check("rst_ready_a", if_a.s_ready, 0);
    check("rst_ready_b", if_b.s_ready, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", if_a.s_ready, 1);

    // Single pixel frame, frame_done 600+1024 cycles after first rise
    drive_slot(0, 64'h800001, 1, st);
    wait_rise(0, n);
    check("t1_rise_latency", n, 1);
    t0 = cyc;
    check("t1_busy", busy_a, 1);
    rx_pixel(0, 24, w0, w1, bad);
    check("t1_data", w0, 32'h800001);
    check("t1_shape", bad, 0);
    wait_done(0, n, h);
    check("t1_latch_len", n, 1024);
    check("t1_latch_low", h, 0);
    check("t1_idle_at_done", busy_a, 0);
    tick();
    check("t1_done_pulse_len", fd_a, 0);
    check("t1_done_cycle", fd_cyc_a - t0, 1624);

    // Three slots, valid held high
    fd0 = fd_cnt_a;
    fork
      begin
        drive_slot(0, 64'hA5F00F, 0, st);
        drive_slot(0, 64'h0123FF, 0, st);
        check("t2_stall_slot1", st, 0);
        drive_slot(0, 64'hC3C3C3, 1, st);
        check("t2_stall_slot2", st, 599);
      end
      begin
        wait_rise(0, n);
        rx_pixel(0, 24, w0, w1, bad);
        check("t2_pix0", w0, 32'hA5F00F);
        check("t2_shape0", bad, 0);
        rx_pixel(0, 24, w0, w1, bad);
        check("t2_pix1", w0, 32'h0123FF);
        check("t2_shape1", bad, 0);
        rx_pixel(0, 24, w0, w1, bad);
        check("t2_pix2", w0, 32'hC3C3C3);
        check("t2_shape2", bad, 0);
        wait_done(0, n, h);
        check("t2_latch_len", n, 1024);
      end
    join
    tick();
    check("t2_done_count", fd_cnt_a - fd0, 1);

    // Underrun, late last slot arrives inside the latch period
    fd0 = fd_cnt_a; ur0 = ur_cnt_a;
    fork
      begin
        drive_slot(0, 64'h00FF00, 0, st);
        n0 = cyc;
        while (cyc < n0 + 701) tick();
        check("t3_ready_in_drop", if_a.s_ready, 1);
        drive_slot(0, 64'hFFFFFF, 1, st);
      end
      begin
        wait_rise(0, n);
        t0 = cyc;
        rx_pixel(0, 24, w0, w1, bad);
        check("t3_data", w0, 32'h00FF00);
        wait_done(0, n, h);
        check("t3_latch_len", n, 1024);
        check("t3_no_extra_pixel", h, 0);
      end
    join
    tick();
    check("t3_underrun_cycle", ur_cyc_a - t0, 599);
    check("t3_underrun_count", ur_cnt_a - ur0, 1);
    check("t3_done_count", fd_cnt_a - fd0, 1);

    // Underrun, late last slot arrives after TRES has expired
    fork
      begin
        drive_slot(0, 64'h0F0F0F, 0, st);
        n0 = cyc;
        while (cyc < n0 + 1801) tick();
        check("t3b_still_res", busy_a, 1);
        drive_slot(0, 64'hFFFFFF, 1, st);
      end
      begin
        wait_rise(0, n);
        rx_pixel(0, 24, w0, w1, bad);
        check("t3b_data", w0, 32'h0F0F0F);
        wait_done(0, n, h);
        check("t3b_wait_for_drop", n, 1202);
        check("t3b_no_extra_pixel", h, 0);
      end
    join
    tick();

    // Two channels, 32 bits
    drive_slot(1, {32'hFF000000, 32'h000000FF}, 1, st);
    wait_rise(1, n);
    check("t4_rise_both", led_b, 2'b11);
    rx_pixel(1, 32, w0, w1, bad);
    check("t4_ch1", w1, 32'hFF000000);
    check("t4_ch0", w0, 32'h000000FF);
    check("t4_shape_aligned", bad, 0);
    wait_done(1, n, h);
    check("t4_latch_len", n, 1024);
    tick();
    check("t4_done_count", fd_cnt_b, 1);
    check("t4_no_underrun", ur_cnt_b, 0);
    check("t4_idle", busy_b, 0);

    // Reset mid-pixel at bit 10
    fd0 = fd_cnt_a;
    drive_slot(0, 64'hFFFFFF, 1, st);
    wait_rise(0, n);
    repeat (325) tick();
    check("t5_bit10_high", led_a, 1);
    reset = 1'b1;
    tick();
    check("t5_led", led_a, 0);
    check("t5_busy", busy_a, 0);
    check("t5_ready", if_a.s_ready, 0);
    reset = 1'b0;
    repeat (1300) tick();
    check("t5_no_done", fd_cnt_a - fd0, 0);
    drive_slot(0, 64'h5A5A5A, 1, st);
    wait_rise(0, n);
    check("t5_restart_latency", n, 1);
    rx_pixel(0, 24, w0, w1, bad);
    check("t5_data", w0, 32'h5A5A5A);
    check("t5_shape", bad, 0);
    wait_done(0, n, h);
    check("t5_latch_len", n, 1024);
    tick();

    // Back-to-back frames, second slot offered during RES
    fork
      begin
        drive_slot(0, 64'h123456, 1, st);
        n0 = cyc;
        while (cyc < n0 + 701) tick();
        drive_slot(0, 64'h654321, 1, st);
        check("t6_stall_in_res", st, 924);
      end
      begin
        wait_rise(0, n);
        rx_pixel(0, 24, w0, w1, bad);
        check("t6_pix0", w0, 32'h123456);
        wait_done(0, n, h);
        check("t6_latch0", n, 1024);
        wait_rise(0, n);
        check("t6_restart_gap", n, 2);
        rx_pixel(0, 24, w0, w1, bad);
        check("t6_pix1", w0, 32'h654321);
        check("t6_shape1", bad, 0);
        wait_done(0, n, h);
        check("t6_latch1", n, 1024);
      end
    join
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
